pcie_tx_arbiter: RTL and testbench

- Shares the endpoint core's 64-bit TRN Tx local-link between two TLP sources.
  - Port 0: completion generator, which answers BAR memory reads.
  - Port 1: posted-request source (DMA writes and user messages).
- Arbitration is round-robin and packet-locked: once a TLP starts, its grant holds from SOF through EOF.
- A TLP starts only when the core reports buffer credit for that TLP type.
- Sits between the user TLP generators and the endpoint core Tx ports. Also keeps per-port TLP counters and a sticky framing-error flag.

---
 rtl/pcie_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin, packet-locked arbiter merging two TRN Tx TLP sources onto the core's 64-bit Tx link.
// Latency: one registered grant cycle after the request, then beats pass through combinationally.
// Backpressure: core trn_tdst_rdy_n reaches only the granted port; the other port sees not-ready.
module pcie_tx_arbiter #(
   parameter int AV_BIT0   = 2,
   parameter int AV_BIT1   = 1,
   parameter int MAX_BEATS = 32,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             trn_reset_n,
   input  logic [63:0]      req0_td,
   input  logic [7:0]       req0_rem_n,
   input  logic             req0_sof_n,
   input  logic             req0_eof_n,
   input  logic             req0_src_rdy_n,
   output logic             req0_dst_rdy_n,
   input  logic [63:0]      req1_td,
   input  logic [7:0]       req1_rem_n,
   input  logic             req1_sof_n,
   input  logic             req1_eof_n,
   input  logic             req1_src_rdy_n,
   output logic             req1_dst_rdy_n,
   output logic [63:0]      trn_td,
   output logic [7:0]       trn_trem_n,
   output logic             trn_tsof_n,
   output logic             trn_teof_n,
   output logic             trn_tsrc_rdy_n,
   output logic             trn_tsrc_dsc_n,
   input  logic             trn_tdst_rdy_n,
   input  logic [3:0]       trn_tbuf_av,
   output logic [CNT_W-1:0] tlp_cnt0,
   output logic [CNT_W-1:0] tlp_cnt1,
   output logic             err,
   input  logic             err_clr
);

   localparam int              BC_W    = $clog2(MAX_BEATS + 1);
   localparam logic [BC_W-1:0] BC_MAX  = BC_W'(MAX_BEATS);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BEATS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

   state_t          state;
   logic            last;
   logic [BC_W-1:0] beat_cnt;
   logic            elig0;
   logic            elig1;
   logic            xfer;
   logic            tlp_end;
   logic            sof_err;
   logic            len_err;
   logic            unused_av;

   // Credit is only consulted here, at TLP start; a mid-packet drop cannot break the lock.
   assign elig0     = ~req0_src_rdy_n & ~req0_sof_n & trn_tbuf_av[AV_BIT0];
   assign elig1     = ~req1_src_rdy_n & ~req1_sof_n & trn_tbuf_av[AV_BIT1];
   assign unused_av = ^trn_tbuf_av;

   // Route the granted port to the core; everything idles outside a grant.
   always_comb begin
      trn_td         = '0;
      trn_trem_n     = 8'h00;
      trn_tsof_n     = 1'b1;
      trn_teof_n     = 1'b1;
      trn_tsrc_rdy_n = 1'b1;
      req0_dst_rdy_n = 1'b1;
      req1_dst_rdy_n = 1'b1;
      case (state)
         GRANT0: begin
            trn_td         = req0_td;
            trn_trem_n     = req0_rem_n;
            trn_tsof_n     = req0_sof_n;
            trn_teof_n     = req0_eof_n;
            trn_tsrc_rdy_n = req0_src_rdy_n;
            req0_dst_rdy_n = trn_tdst_rdy_n;
         end
         GRANT1: begin
            trn_td         = req1_td;
            trn_trem_n     = req1_rem_n;
            trn_tsof_n     = req1_sof_n;
            trn_teof_n     = req1_eof_n;
            trn_tsrc_rdy_n = req1_src_rdy_n;
            req1_dst_rdy_n = trn_tdst_rdy_n;
         end
         default: ;
      endcase
   end

   assign trn_tsrc_dsc_n = 1'b1;
   assign xfer           = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
   assign tlp_end        = xfer & ~trn_teof_n;
   // A second SOF inside a packet, or a packet that reaches MAX_BEATS without ending.
   assign sof_err        = xfer & ~trn_tsof_n & (beat_cnt != '0);
   assign len_err        = xfer & trn_teof_n & (beat_cnt == BC_LAST);

   // Grant FSM: pick a port in IDLE, hold it until its EOF beat transfers.
   always_ff @(posedge clk or negedge trn_reset_n) begin
      if (!trn_reset_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         beat_cnt <= '0;
         tlp_cnt0 <= '0;
         tlp_cnt1 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (elig0 && (!elig1 || last)) begin
                  state <= GRANT0;
               end else if (elig1) begin
                  state <= GRANT1;
               end
            end
            GRANT0, GRANT1: begin
               if (tlp_end) begin
                  state    <= IDLE;
                  last     <= (state == GRANT1);
                  beat_cnt <= '0;
                  if (state == GRANT1) begin
                     tlp_cnt1 <= tlp_cnt1 + 1'b1;
                  end else begin
                     tlp_cnt0 <= tlp_cnt0 + 1'b1;
                  end
               end else if (xfer && (beat_cnt != BC_MAX)) begin
                  // Saturate so an over-long packet cannot wrap back to zero.
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky framing error; a new error in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge trn_reset_n) begin
      if (!trn_reset_n) begin
         err <= 1'b0;
      end else begin
         err <= (err & ~err_clr) | sof_err | len_err;
      end
   end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for pcie_tx_arbiter: directed scenarios plus randomized traffic.
// A transaction-level model predicts every output each cycle from the arbitration rules.
// Sources and core are randomized for stalls, backpressure, credit and error clears.
module tb_pcie_tx_arbiter;

   localparam int AV_BIT0   = 2;
   localparam int AV_BIT1   = 1;
   localparam int MAX_BEATS = 32;
   localparam int CNT_W     = 16;

   logic              clk = 1'b0;
   logic              trn_reset_n = 1'b1;
   logic [63:0]       req0_td, req1_td;
   logic [7:0]        req0_rem_n, req1_rem_n;
   logic              req0_sof_n, req1_sof_n, req0_eof_n, req1_eof_n;
   logic              req0_src_rdy_n, req1_src_rdy_n;
   logic              req0_dst_rdy_n, req1_dst_rdy_n;
   logic [63:0]       trn_td;
   logic [7:0]        trn_trem_n;
   logic              trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
   logic              trn_tdst_rdy_n = 1'b1;
   logic [3:0]        trn_tbuf_av = 4'hF;
   logic [CNT_W-1:0]  tlp_cnt0, tlp_cnt1;
   logic              err;
   logic              err_clr = 1'b0;

   pcie_tx_arbiter #(.AV_BIT0(AV_BIT0), .AV_BIT1(AV_BIT1), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
      .clk(clk), .trn_reset_n(trn_reset_n),
      .req0_td(req0_td), .req0_rem_n(req0_rem_n), .req0_sof_n(req0_sof_n), .req0_eof_n(req0_eof_n),
      .req0_src_rdy_n(req0_src_rdy_n), .req0_dst_rdy_n(req0_dst_rdy_n),
      .req1_td(req1_td), .req1_rem_n(req1_rem_n), .req1_sof_n(req1_sof_n), .req1_eof_n(req1_eof_n),
      .req1_src_rdy_n(req1_src_rdy_n), .req1_dst_rdy_n(req1_dst_rdy_n),
      .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
      .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
      .trn_tbuf_av(trn_tbuf_av), .tlp_cnt0(tlp_cnt0), .tlp_cnt1(tlp_cnt1), .err(err), .err_clr(err_clr)
   );

   // 62.5 MHz TRN clock
   always #8 clk = ~clk;

   typedef struct {
      int          len;
      int          sof_at;
      logic [63:0] first;
      logic [7:0]  rem;
   } tlp_t;

   tlp_t        srcq [2][$];
   int          cur [2] = '{0, 0};
   logic        started [2] = '{1'b0, 1'b0};
   int          drv0_cyc [2] = '{0, 0};
   logic [63:0] p_td [2] = '{64'd0, 64'd0};
   logic [7:0]  p_rem [2] = '{8'h00, 8'h00};
   logic        p_sof [2] = '{1'b1, 1'b1};
   logic        p_eof [2] = '{1'b1, 1'b1};
   logic        p_src [2] = '{1'b1, 1'b1};
   logic        acc [2] = '{1'b0, 1'b0};

   assign req0_td = p_td[0];  assign req0_rem_n = p_rem[0];  assign req0_sof_n = p_sof[0];
   assign req0_eof_n = p_eof[0];  assign req0_src_rdy_n = p_src[0];
   assign req1_td = p_td[1];  assign req1_rem_n = p_rem[1];  assign req1_sof_n = p_sof[1];
   assign req1_eof_n = p_eof[1];  assign req1_src_rdy_n = p_src[1];

   // knobs set by the test sequence
   int         stall_pct = 0;
   int         bp_pct = 0;
   logic       force_bp = 1'b0;
   logic       rand_av = 1'b0;
   logic       rand_clr = 1'b0;
   logic       clr_knob = 1'b0;
   logic [3:0] av_knob = 4'hF;
   logic       prev_av0 = 1'b1;
   int         av_rise_cyc = 0;
   int         cyc_n = 0;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Sources and core stimulus, applied just after each rising edge.
   always @(posedge clk) begin
      tlp_t t;
      #1;
      for (int p = 0; p < 2; p++) begin
         if (!trn_reset_n) begin
            srcq[p].delete();
            cur[p] = 0;
            started[p] = 1'b0;
         end else if (acc[p] && srcq[p].size() > 0) begin
            cur[p]++;
            if (cur[p] == srcq[p][0].len) begin
               void'(srcq[p].pop_front());
               cur[p] = 0;
               started[p] = 1'b0;
            end
         end
         if (srcq[p].size() > 0 && $urandom_range(99) >= stall_pct) begin
            t = srcq[p][0];
            p_src[p] = 1'b0;
            p_sof[p] = !(cur[p] == 0 || cur[p] == t.sof_at);
            p_eof[p] = !(cur[p] == t.len - 1);
            p_td[p]  = (cur[p] == 0) ? t.first : {$urandom, $urandom};
            p_rem[p] = (cur[p] == t.len - 1) ? t.rem : 8'h00;
            if (cur[p] == 0 && !started[p]) begin
               drv0_cyc[p] = cyc_n;
               started[p] = 1'b1;
            end
         end else begin
            p_src[p] = 1'b1;
            p_sof[p] = 1'($urandom_range(1));
            p_eof[p] = 1'($urandom_range(1));
            p_td[p]  = {$urandom, $urandom};
            p_rem[p] = 8'($urandom);
         end
      end
      trn_tdst_rdy_n = force_bp || ($urandom_range(99) < bp_pct);
      trn_tbuf_av = rand_av ? 4'($urandom_range(15)) : av_knob;
      if (trn_tbuf_av[AV_BIT0] && !prev_av0) av_rise_cyc = cyc_n;
      prev_av0 = trn_tbuf_av[AV_BIT0];
      err_clr = clr_knob || (rand_clr && $urandom_range(15) == 0);
   end

   // Transaction-level model: who owns the link, how far into the packet, counters, error.
   int m_owner = -1;
   int m_last = 1;
   int m_beats = 0;
   int m_cnt [2] = '{0, 0};
   bit m_err = 1'b0;

   always @(posedge clk or negedge trn_reset_n) begin
      bit e0, e1, x, nerr, s_n, eo_n;
      if (!trn_reset_n) begin
         m_owner = -1; m_last = 1; m_beats = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_err = 1'b0;
      end else begin
         nerr = 1'b0;
         if (m_owner < 0) begin
            e0 = !req0_src_rdy_n && !req0_sof_n && trn_tbuf_av[AV_BIT0];
            e1 = !req1_src_rdy_n && !req1_sof_n && trn_tbuf_av[AV_BIT1];
            if (e0 && e1) m_owner = 1 - m_last;
            else if (e0) m_owner = 0;
            else if (e1) m_owner = 1;
         end else begin
            x    = (m_owner == 0 ? !req0_src_rdy_n : !req1_src_rdy_n) && !trn_tdst_rdy_n;
            s_n  = (m_owner == 0) ? req0_sof_n : req1_sof_n;
            eo_n = (m_owner == 0) ? req0_eof_n : req1_eof_n;
            if (x) begin
               if (!s_n && m_beats > 0) nerr = 1'b1;
               m_beats++;
               if (!eo_n) begin
                  m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CNT_W);
                  m_last = m_owner;
                  m_owner = -1;
                  m_beats = 0;
               end else if (m_beats == MAX_BEATS) begin
                  nerr = 1'b1;
               end
            end
         end
         m_err = (m_err && !err_clr) || nerr;
      end
   end

   // Core-side log of transferred beats
   int          lg_port [$];
   int          sof_port [$];
   int          sof_cyc [$];
   logic [63:0] sof_td [$];

   logic [63:0] e_td;
   logic [7:0]  e_rem;
   logic        e_sof, e_eof, e_src, e_d0, e_d1;

   // Compare every DUT output against the model, mid-cycle.
   always @(negedge clk) begin
      e_td = '0; e_rem = 8'h00; e_sof = 1'b1; e_eof = 1'b1; e_src = 1'b1; e_d0 = 1'b1; e_d1 = 1'b1;
      if (m_owner == 0) begin
         e_td = req0_td; e_rem = req0_rem_n; e_sof = req0_sof_n; e_eof = req0_eof_n;
         e_src = req0_src_rdy_n; e_d0 = trn_tdst_rdy_n;
      end else if (m_owner == 1) begin
         e_td = req1_td; e_rem = req1_rem_n; e_sof = req1_sof_n; e_eof = req1_eof_n;
         e_src = req1_src_rdy_n; e_d1 = trn_tdst_rdy_n;
      end
      chk("trn_td", trn_td, e_td);
      chk("trn_trem_n", trn_trem_n, e_rem);
      chk("trn_tsof_n", trn_tsof_n, e_sof);
      chk("trn_teof_n", trn_teof_n, e_eof);
      chk("trn_tsrc_rdy_n", trn_tsrc_rdy_n, e_src);
      chk("trn_tsrc_dsc_n", trn_tsrc_dsc_n, 1'b1);
      chk("req0_dst_rdy_n", req0_dst_rdy_n, e_d0);
      chk("req1_dst_rdy_n", req1_dst_rdy_n, e_d1);
      chk("tlp_cnt0", tlp_cnt0, m_cnt[0]);
      chk("tlp_cnt1", tlp_cnt1, m_cnt[1]);
      chk("err", err, m_err);
      acc[0] = !req0_src_rdy_n && !req0_dst_rdy_n;
      acc[1] = !req1_src_rdy_n && !req1_dst_rdy_n;
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
         lg_port.push_back(!req0_dst_rdy_n ? 0 : (!req1_dst_rdy_n ? 1 : 9));
         if (!trn_tsof_n && m_beats == 0) begin
            sof_port.push_back(!req0_dst_rdy_n ? 0 : 1);
            sof_cyc.push_back(cyc_n);
            sof_td.push_back(trn_td);
         end
      end
   end

   task automatic push(input int p, input int len, input int sof_at, input logic [63:0] first,
                       input logic [7:0] rem);
      tlp_t t;
      t.len = len; t.sof_at = sof_at; t.first = first; t.rem = rem;
      srcq[p].push_back(t);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while ((srcq[0].size() != 0 || srcq[1].size() != 0 || m_owner >= 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) begin
         n_chk++; n_fail++;
         $display("FAIL %s: link still busy after %0d cycles, required idle", name, budget);
      end
      @(negedge clk);
   endtask

   task automatic wait_sof(input string name, input int n, input int budget);
      int k = 0;
      while (sof_port.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) begin
         n_chk++; n_fail++;
         $display("FAIL %s: %0d SOFs seen, required %0d", name, sof_port.size(), n);
      end
   endtask

   task automatic clear_err();
      clr_knob = 1'b1;
      @(negedge clk);
      clr_knob = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int sb, lb, e_cnt0, e_cnt1;
      logic [5:0] exp_b;
      e_cnt0 = 0; e_cnt1 = 0;

      // reset state
      #1 trn_reset_n = 1'b0;
      #3;
      chk("rst_tsrc_rdy_n", trn_tsrc_rdy_n, 1'b1);
      chk("rst_tsof_n", trn_tsof_n, 1'b1);
      chk("rst_dst_rdy0", req0_dst_rdy_n, 1'b1);
      chk("rst_dst_rdy1", req1_dst_rdy_n, 1'b1);
      chk("rst_cnt0", tlp_cnt0, 0);
      chk("rst_err", err, 1'b0);
      @(negedge clk); @(negedge clk);
      trn_reset_n = 1'b1;
      @(negedge clk);

      // single 2-beat completion on port 0
      sb = sof_port.size(); lb = lg_port.size();
      push(0, 2, -1, 64'h4A000001_00000004, 8'h00); e_cnt0++;
      wait_idle("t1_idle", 50);
      chk("t1_sof_td", sof_td[sb], 64'h4A000001_00000004);
      chk("t1_latency", sof_cyc[sb] - drv0_cyc[0], 1);
      chk("t1_beats", lg_port.size() - lb, 2);
      chk("t1_cnt0", tlp_cnt0, e_cnt0);
      chk("t1_model_cnt0", m_cnt[0], e_cnt0);
      chk("t1_err", err, 1'b0);

      // single-beat TLP on port 1 leaves last=1, then contention 0,1,0,1
      push(1, 1, -1, 64'h0123_4567_89AB_CDEF, 8'h0F); e_cnt1++;
      wait_idle("t2a_idle", 50);
      chk("t2a_cnt1", tlp_cnt1, e_cnt1);
      sb = sof_port.size();
      push(0, 2, -1, 64'hA0, 8'h00); push(0, 2, -1, 64'hA1, 8'h00);
      push(1, 2, -1, 64'hB0, 8'h00); push(1, 2, -1, 64'hB1, 8'h00);
      e_cnt0 += 2; e_cnt1 += 2;
      wait_idle("t2_idle", 100);
      for (int k = 0; k < 4; k++) chk("t2_grant_order", sof_port[sb + k], k % 2);
      for (int k = 1; k < 4; k++) chk("t2_turnaround", sof_cyc[sb + k] - sof_cyc[sb + k - 1], 3);
      chk("t2_cnt0", tlp_cnt0, e_cnt0);
      chk("t2_cnt1", tlp_cnt1, e_cnt1);

      // credit gating: only the posted buffer has room
      av_knob = 4'b0010;
      sb = sof_port.size();
      push(0, 2, -1, 64'hC0, 8'h00); push(1, 2, -1, 64'hD0, 8'h00);
      e_cnt0++; e_cnt1++;
      wait_sof("t3_p1", sb + 1, 50);
      repeat (8) @(negedge clk);
      chk("t3_only_p1_sofs", sof_port.size() - sb, 1);
      chk("t3_first_port", sof_port[sb], 1);
      chk("t3_cnt0_held", tlp_cnt0, e_cnt0 - 1);
      av_knob = 4'b0110;
      wait_idle("t3_idle", 50);
      chk("t3_second_port", sof_port[sb + 1], 0);
      chk("t3_start_after_credit", sof_cyc[sb + 1] - av_rise_cyc, 1);
      av_knob = 4'hF;

      // core backpressure mid-packet while port 1 waits
      sb = sof_port.size(); lb = lg_port.size();
      push(0, 4, -1, 64'hE0, 8'h00); e_cnt0++;
      wait_sof("t4_p0", sb + 1, 50);
      force_bp = 1'b1;
      push(1, 2, -1, 64'hF0, 8'h0F); e_cnt1++;
      repeat (5) begin
         @(negedge clk);
         chk("t4_stall_dst_rdy0", req0_dst_rdy_n, 1'b1);
         chk("t4_stall_dst_rdy1", req1_dst_rdy_n, 1'b1);
      end
      force_bp = 1'b0;
      wait_idle("t4_idle", 60);
      exp_b = 6'b110000;
      chk("t4_beat_count", lg_port.size() - lb, 6);
      for (int k = 0; k < 6; k++) chk("t4_beat_port", lg_port[lb + k], exp_b[k]);

      // framing errors
      push(0, 3, 1, 64'h11, 8'h00); e_cnt0++;
      wait_idle("t5a_idle", 50);
      chk("t5_sof_err", err, 1'b1);
      chk("t5_sof_cnt0", tlp_cnt0, e_cnt0);
      clear_err();
      chk("t5_clr", err, 1'b0);
      push(0, MAX_BEATS, -1, 64'h22, 8'h00); e_cnt0++;
      wait_idle("t5b_idle", 100);
      chk("t5_max_len_ok", err, 1'b0);
      push(0, MAX_BEATS + 1, -1, 64'h33, 8'h00); e_cnt0++;
      wait_idle("t5c_idle", 100);
      chk("t5_len_err", err, 1'b1);
      chk("t5_len_cnt0", tlp_cnt0, e_cnt0);
      clear_err();
      chk("t5_clr2", err, 1'b0);

      // reset on beat 1 of a 4-beat TLP
      sb = sof_port.size();
      push(0, 4, -1, 64'h44, 8'h00);
      wait_sof("t6_p0", sb + 1, 50);
      @(posedge clk);
      #3 trn_reset_n = 1'b0;
      #1;
      chk("t6_async_src_rdy", trn_tsrc_rdy_n, 1'b1);
      chk("t6_async_dst_rdy0", req0_dst_rdy_n, 1'b1);
      chk("t6_async_cnt0", tlp_cnt0, 0);
      chk("t6_async_cnt1", tlp_cnt1, 0);
      repeat (3) @(negedge clk);
      trn_reset_n = 1'b1;
      e_cnt0 = 0; e_cnt1 = 0;
      @(negedge clk);
      sb = sof_port.size(); lb = lg_port.size();
      push(0, 2, -1, 64'hDEADBEEF_0BADF00D, 8'h0F); e_cnt0++;
      wait_idle("t6_idle", 50);
      chk("t6_fresh_td", sof_td[sb], 64'hDEADBEEF_0BADF00D);
      chk("t6_fresh_beats", lg_port.size() - lb, 2);
      chk("t6_fresh_cnt0", tlp_cnt0, e_cnt0);

      // randomized traffic
      stall_pct = 25; bp_pct = 30; rand_av = 1'b1; rand_clr = 1'b1;
      for (int i = 0; i < 400; i++) begin
         int p, len, sat;
         p = int'($urandom_range(1));
         len = ($urandom_range(19) == 0) ? int'($urandom_range(36, 30)) : int'($urandom_range(6, 1));
         sat = (len > 1 && $urandom_range(9) == 0) ? int'($urandom_range(len - 1, 1)) : -1;
         push(p, len, sat, {$urandom, $urandom}, ($urandom_range(1) == 1) ? 8'h0F : 8'h00);
      end
      wait_idle("t7_idle", 40000);
      stall_pct = 0; bp_pct = 0; rand_av = 1'b0; rand_clr = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
